bus_slave_port: RTL and testbench
=================================

# bus_slave_port

Serial-bus responder engine: the target-side counterpart of the bus `master`. It watches the shared serial bus while `b_bus_utilizing` is high, deserialises the address frame and decodes the slave ID. On an ID match it asserts `slave_busy` and runs the write or read transfer against a local parallel memory port. It sits between the top-level open-drain bus nets and one memory or peripheral slave. Tri-state resolution of `b_BUS` stays in the top module, driven from `b_bus_out`/`b_bus_oe`.

## Interface
- DATA_WIDTH, 8, data word width
- ADDRS_WIDTH, 15, full serial address width (ID + local)
- ID_WIDTH, 3, slave-ID field width, address MSBs
- SELF_ID, 3'b101, ID this port answers to
- RD_TIMEOUT_LEN, 6, memory read wait limit in bits (2^6 = 64 clocks)

Ports:
- clk  in  1  system clock; one clock domain.
- rstn  in  1  asynchronous, active-low reset.
- b_bus_in  in  1  sampled `b_BUS` level.
- b_RW  in  1  1 = write, 0 = read; valid while `b_bus_utilizing` is high.
- b_bus_utilizing  in  1  frame envelope driven by the granted master.
- b_bus_out  out  1  serial read-data bit.
- b_bus_oe  out  1  drive enable for `b_BUS`.
- slave_busy  out  1  target selected and active.
- mem_addr  out  ADDRS_WIDTH-ID_WIDTH  local address.
- mem_wdata  out  DATA_WIDTH  write data.
- mem_wr  out  1  one-cycle write strobe.
- mem_rd  out  1  one-cycle read request.
- mem_rdata  in  DATA_WIDTH  read data.
- mem_rvalid  in  1  `mem_rdata` valid, single cycle.

## Operation
- States: IDLE, ADDR, IGNORE, WDATA, WRITE, RWAIT, RDATA, DONE.
- IDLE → ADDR on the first `clk` edge where `b_bus_utilizing` = 1. That edge also samples address bit ADDRS_WIDTH-1.
- Serial order is MSB first. Frame is address bits, then data bits for a write.
- After ID_WIDTH bits are received, the ID field is compared with SELF_ID.
  - Mismatch → IGNORE. IGNORE holds until `b_bus_utilizing` = 0, then → IDLE. No outputs change.
  - Match → stay in ADDR and assert `slave_busy`.
- Last address bit received:
  - `b_RW` = 1 → WDATA.
  - `b_RW` = 0 → RWAIT, with `mem_rd` pulsed on entry.
- WDATA shifts in DATA_WIDTH bits, then → WRITE. WRITE lasts one cycle with `mem_wr` = 1 and stable `mem_addr`/`mem_wdata`, then → DONE.
- RWAIT:
  - On `mem_rvalid`, latch `mem_rdata` → RDATA.
  - If 2^RD_TIMEOUT_LEN cycles pass with no valid → DONE. No bus drive occurs; the master's own timeout handles the failure.
- RDATA: `b_bus_oe` = 1 for exactly DATA_WIDTH cycles, `b_bus_out` = data MSB first, then → DONE.
- DONE: `slave_busy` = 0 and `b_bus_oe` = 0; wait for `b_bus_utilizing` = 0, then → IDLE.
- Abort: `b_bus_utilizing` falling in ADDR, WDATA, RWAIT or RDATA → IDLE next cycle.
  - No `mem_wr` is issued.
  - `slave_busy` and `b_bus_oe` drop immediately.
  - A late `mem_rvalid` is ignored.
- `b_RW` is sampled once, at the last address bit.
- `mem_addr` holds its last value between transfers.

## Timing
- Cycle 0 is the first edge with `b_bus_utilizing` = 1. Address bit ADDRS_WIDTH-1-k is sampled at cycle k.
- `slave_busy` rises in cycle ID_WIDTH (cycle 3 with defaults).
- Write, default widths:
  - data bits at cycles 15..22;
  - `mem_wr` in cycle 23;
  - `slave_busy` low from cycle 24.
- Read:
  - `mem_rd` in cycle 15;
  - `mem_rvalid` at cycle 15+L (L ≥ 0; same-cycle valid is accepted);
  - drive cycles 16+L .. 23+L;
  - `slave_busy` low from cycle 24+L.
- Reset values: `slave_busy` 0, `b_bus_oe` 0, `b_bus_out` 1, `mem_wr` 0, `mem_rd` 0, `mem_addr` 0, `mem_wdata` 0, state IDLE.
- Reset asserted mid-transfer clears everything asynchronously and releases the bus in the same instant.
- All outputs are registered.

## Structure
- Shared package `bus_pkg` holds:
  - the state enum;
  - ID_WIDTH;
  - the slave ID constants;
  - the RW encoding (WRITE = 1, READ = 0).
- One natural sub-module is `serial_shifter`: a parameterised MSB-first shift register with load, shift-in and shift-out. It is instantiated once for address/data-in and once for read-data-out.
- Counters:
  - bit counter, $clog2(ADDRS_WIDTH+1) bits;
  - timeout counter, RD_TIMEOUT_LEN bits, saturating.

## Test plan
- Write hit: frame ID 101, local 12'h0A5, data 8'hCB, `b_RW` = 1 → single `mem_wr` at cycle 23 with addr 12'h0A5 and data 8'hCB; `slave_busy` high cycles 3..23.
- ID miss: ID 011, full write frame → `slave_busy`, `mem_wr`, `mem_rd` and `b_bus_oe` stay 0 throughout; returns to IDLE after `b_bus_utilizing` falls.
- Read hit with latency 3: memory returns 8'h1D → `mem_rd` at cycle 15; `b_bus_out` serialises 0,0,0,1,1,1,0,1 in cycles 19..26 with `b_bus_oe` high exactly those 8 cycles.
- Read timeout: `mem_rvalid` never asserted → `b_bus_oe` never 1; `slave_busy` falls 64 cycles after `mem_rd`.
- Abort: `b_bus_utilizing` drops at cycle 18 of a write → no `mem_wr`; `slave_busy` 0 next cycle; a following good write completes normally.
- Async reset during RDATA → `b_bus_oe` 0 and `b_bus_out` 1 without waiting for a clock edge; state IDLE after release.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: shared bus constants, slave IDs, RW encoding and responder state encoding.
package bus_pkg;
    localparam int ID_WIDTH = 3;
    localparam logic [ID_WIDTH-1:0] SLAVE_ID_MEM = 3'b101;
    localparam logic [ID_WIDTH-1:0] SLAVE_ID_PERIPH = 3'b011;
    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ = 1'b0;
    typedef enum logic [2:0] {IDLE, ADDR, IGNORE, WDATA, WRITE, RWAIT, RDATA, DONE} state_t;
endpackage

// File: rtl/serial_shifter.sv
// serial_shifter: MSB-first shift register with parallel load and serial shift-in.
module serial_shifter
    import bus_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    input  logic             sin,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) q <= '0;
        else if (load) q <= load_data;
        else if (shift) q <= {q[WIDTH-2:0], sin};
    end
endmodule

// File: rtl/bus_slave_port.sv
// bus_slave_port: serial-bus target engine bridging address/data frames to a parallel memory port.
module bus_slave_port #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDRS_WIDTH = 15,
    parameter int ID_WIDTH = bus_pkg::ID_WIDTH,
    parameter logic [ID_WIDTH-1:0] SELF_ID = bus_pkg::SLAVE_ID_MEM,
    parameter int RD_TIMEOUT_LEN = 6
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            b_bus_in,
    input  logic                            b_RW,
    input  logic                            b_bus_utilizing,
    output logic                            b_bus_out,
    output logic                            b_bus_oe,
    output logic                            slave_busy,
    output logic [ADDRS_WIDTH-ID_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    output logic                            mem_wr,
    output logic                            mem_rd,
    input  logic [DATA_WIDTH-1:0]           mem_rdata,
    input  logic                            mem_rvalid
);
    import bus_pkg::*;
    localparam int LW = ADDRS_WIDTH - ID_WIDTH;
    localparam int SW = (LW > DATA_WIDTH) ? LW : DATA_WIDTH;
    localparam int CW = $clog2(ADDRS_WIDTH + 1);

    state_t state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [RD_TIMEOUT_LEN-1:0] tcnt, tcnt_d;
    logic busy_d, oe_d, out_d, wr_d, rd_d;
    logic [LW-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic in_shift, out_load, out_shift, out_last;
    logic [SW-1:0] in_q;
    logic [DATA_WIDTH:0] out_q;

    serial_shifter #(.WIDTH(SW)) u_in (
        .clk(clk), .rstn(rstn), .load(1'b0), .load_data('0),
        .shift(in_shift), .sin(b_bus_in), .q(in_q)
    );

    // A trailing 1 marks the end of the read word: once it reaches the top of the low field, the last bit is out.
    serial_shifter #(.WIDTH(DATA_WIDTH + 1)) u_out (
        .clk(clk), .rstn(rstn), .load(out_load), .load_data({mem_rdata, 1'b1}),
        .shift(out_shift), .sin(1'b0), .q(out_q)
    );

    assign out_last = out_q[DATA_WIDTH-1:0] == {1'b1, {(DATA_WIDTH-1){1'b0}}};

    always_comb begin
        state_d = state;
        cnt_d = cnt;
        tcnt_d = '0;
        busy_d = slave_busy;
        oe_d = 1'b0;
        out_d = 1'b1;
        wr_d = 1'b0;
        rd_d = 1'b0;
        addr_d = mem_addr;
        wdata_d = mem_wdata;
        in_shift = 1'b0;
        out_load = 1'b0;
        out_shift = 1'b0;
        case (state)
            IDLE: begin
                in_shift = b_bus_utilizing;
                cnt_d = b_bus_utilizing ? CW'(1) : cnt;
                state_d = b_bus_utilizing ? ADDR : IDLE;
            end
            ADDR: begin
                if (!b_bus_utilizing) begin
                    state_d = IDLE;
                    busy_d = 1'b0;
                end else begin
                    in_shift = 1'b1;
                    cnt_d = cnt + 1'b1;
                    if (cnt == CW'(ID_WIDTH)) begin
                        busy_d = in_q[ID_WIDTH-1:0] == SELF_ID;
                        state_d = (in_q[ID_WIDTH-1:0] == SELF_ID) ? ADDR : IGNORE;
                    end
                    if (cnt == CW'(ADDRS_WIDTH - 1)) begin
                        state_d = (b_RW == RW_WRITE) ? WDATA : RWAIT;
                        cnt_d = '0;
                    end
                end
            end
            IGNORE: state_d = b_bus_utilizing ? IGNORE : IDLE;
            WDATA: begin
                addr_d = (cnt == '0) ? in_q[LW-1:0] : mem_addr;
                if (!b_bus_utilizing) begin
                    state_d = IDLE;
                    busy_d = 1'b0;
                end else begin
                    in_shift = 1'b1;
                    cnt_d = cnt + 1'b1;
                    state_d = (cnt == CW'(DATA_WIDTH - 1)) ? WRITE : WDATA;
                end
            end
            WRITE: begin
                wr_d = 1'b1;
                wdata_d = in_q[DATA_WIDTH-1:0];
                state_d = DONE;
            end
            RWAIT: begin
                rd_d = tcnt == '0;
                addr_d = (tcnt == '0) ? in_q[LW-1:0] : mem_addr;
                tcnt_d = (&tcnt) ? tcnt : tcnt + 1'b1;
                if (!b_bus_utilizing) begin
                    state_d = IDLE;
                    busy_d = 1'b0;
                end else if (mem_rvalid) begin
                    state_d = RDATA;
                    out_load = 1'b1;
                end else if (&tcnt) begin
                    state_d = DONE;
                end
            end
            RDATA: begin
                if (!b_bus_utilizing) begin
                    state_d = IDLE;
                    busy_d = 1'b0;
                end else begin
                    oe_d = 1'b1;
                    out_d = out_q[DATA_WIDTH];
                    out_shift = 1'b1;
                    state_d = out_last ? DONE : RDATA;
                end
            end
            DONE: begin
                busy_d = 1'b0;
                state_d = b_bus_utilizing ? DONE : IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cnt <= '0;
            tcnt <= '0;
            slave_busy <= 1'b0;
            b_bus_oe <= 1'b0;
            b_bus_out <= 1'b1;
            mem_wr <= 1'b0;
            mem_rd <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
        end else begin
            state <= state_d;
            cnt <= cnt_d;
            tcnt <= tcnt_d;
            slave_busy <= busy_d;
            b_bus_oe <= oe_d;
            b_bus_out <= out_d;
            mem_wr <= wr_d;
            mem_rd <= rd_d;
            mem_addr <= addr_d;
            mem_wdata <= wdata_d;
        end
    end
endmodule

// File: tb/tb_bus_slave_port.sv
// tb_bus_slave_port: directed frames against bus_slave_port with per-cycle output traces.
module tb_bus_slave_port;
    import bus_pkg::*;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic b_bus_in = 1'b1;
    logic b_RW = 1'b0;
    logic b_bus_utilizing = 1'b0;
    logic mem_rvalid = 1'b0;
    logic [7:0] mem_rdata = 8'h00;
    logic b_bus_out, b_bus_oe, slave_busy, mem_wr, mem_rd;
    logic [11:0] mem_addr;
    logic [7:0] mem_wdata;
    int n_chk = 0;
    int n_pass = 0;
    logic busy_t [128];
    logic oe_t [128];
    logic out_t [128];
    logic wr_t [128];
    logic rd_t [128];
    logic [11:0] addr_t [128];
    logic [7:0] wdata_t [128];
    int n_busy, n_wr, n_rd, n_oe;
    logic [7:0] rbyte;

    always #5 clk = ~clk;

    bus_slave_port dut (
        .clk(clk), .rstn(rstn), .b_bus_in(b_bus_in), .b_RW(b_RW),
        .b_bus_utilizing(b_bus_utilizing), .b_bus_out(b_bus_out), .b_bus_oe(b_bus_oe),
        .slave_busy(slave_busy), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Cycle k inputs are set before edge k; outputs after edge k are recorded as cycle k.
    task automatic frame(input logic [14:0] addr, input logic rw, input logic [7:0] wd,
                         input int lat, input logic [7:0] rd, input int stop, input int ncyc);
        n_busy = 0;
        n_wr = 0;
        n_rd = 0;
        n_oe = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            b_bus_utilizing = k < stop;
            b_RW = rw;
            b_bus_in = (k < 15) ? addr[14-k] : ((rw && k < 23) ? wd[22-k] : 1'b1);
            mem_rvalid = lat >= 0 && k == 15 + lat;
            mem_rdata = mem_rvalid ? rd : 8'h00;
            @(posedge clk);
            #1;
            busy_t[k] = slave_busy;
            oe_t[k] = b_bus_oe;
            out_t[k] = b_bus_out;
            wr_t[k] = mem_wr;
            rd_t[k] = mem_rd;
            addr_t[k] = mem_addr;
            wdata_t[k] = mem_wdata;
            n_busy += int'(slave_busy);
            n_wr += int'(mem_wr);
            n_rd += int'(mem_rd);
            n_oe += int'(b_bus_oe);
        end
    endtask

    initial begin
        #12;
        check("rst_busy", slave_busy, 0);
        check("rst_oe", b_bus_oe, 0);
        check("rst_out", b_bus_out, 1);
        check("rst_wr", mem_wr, 0);
        check("rst_rd", mem_rd, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        @(negedge clk);
        rstn = 1'b1;

        frame({3'b101, 12'h0A5}, 1'b1, 8'hCB, -1, 8'h00, 26, 28);
        check("wr_cnt", n_wr, 1);
        check("wr_cyc23", wr_t[23], 1);
        check("wr_addr", addr_t[23], 12'h0A5);
        check("wr_data", wdata_t[23], 8'hCB);
        check("wr_busy2", busy_t[2], 0);
        check("wr_busy3", busy_t[3], 1);
        check("wr_busy23", busy_t[23], 1);
        check("wr_busy24", busy_t[24], 0);
        check("wr_busy_len", n_busy, 21);
        check("wr_no_oe", n_oe, 0);
        check("wr_no_rd", n_rd, 0);

        frame({3'b011, 12'h0A5}, 1'b1, 8'hCB, -1, 8'h00, 26, 28);
        check("miss_busy", n_busy, 0);
        check("miss_wr", n_wr, 0);
        check("miss_rd", n_rd, 0);
        check("miss_oe", n_oe, 0);
        check("miss_idle", 32'(dut.state), 32'(IDLE));

        frame({3'b101, 12'h3C7}, 1'b0, 8'h00, 3, 8'h1D, 30, 32);
        check("rd_cnt", n_rd, 1);
        check("rd_cyc15", rd_t[15], 1);
        check("rd_addr", addr_t[15], 12'h3C7);
        check("rd_oe_len", n_oe, 8);
        check("rd_oe18", oe_t[18], 0);
        check("rd_oe19", oe_t[19], 1);
        check("rd_oe26", oe_t[26], 1);
        check("rd_oe27", oe_t[27], 0);
        rbyte = 8'h00;
        for (int k = 19; k <= 26; k++) rbyte = {rbyte[6:0], out_t[k]};
        check("rd_serial", rbyte, 8'h1D);
        check("rd_busy26", busy_t[26], 1);
        check("rd_busy27", busy_t[27], 0);
        check("rd_no_wr", n_wr, 0);

        frame({3'b101, 12'h111}, 1'b0, 8'h00, -1, 8'h00, 82, 84);
        check("to_no_oe", n_oe, 0);
        check("to_rd15", rd_t[15], 1);
        check("to_busy78", busy_t[78], 1);
        check("to_busy79", busy_t[79], 0);

        frame({3'b101, 12'h0A5}, 1'b1, 8'hCB, -1, 8'h00, 18, 20);
        check("ab_no_wr", n_wr, 0);
        check("ab_busy17", busy_t[17], 1);
        check("ab_busy18", busy_t[18], 0);
        frame({3'b101, 12'h5A3}, 1'b1, 8'h3C, -1, 8'h00, 26, 28);
        check("ab_wr23", wr_t[23], 1);
        check("ab_addr", addr_t[23], 12'h5A3);
        check("ab_data", wdata_t[23], 8'h3C);

        frame({3'b101, 12'h222}, 1'b0, 8'h00, 0, 8'hA5, 40, 18);
        check("rs_oe17", oe_t[17], 1);
        check("rs_out16", out_t[16], 1);
        check("rs_out17", out_t[17], 0);
        #2;
        rstn = 1'b0;
        #1;
        check("rs_async_oe", b_bus_oe, 0);
        check("rs_async_out", b_bus_out, 1);
        check("rs_async_busy", slave_busy, 0);
        b_bus_utilizing = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("rs_idle", 32'(dut.state), 32'(IDLE));
        frame({3'b101, 12'h123}, 1'b1, 8'h5E, -1, 8'h00, 26, 28);
        check("rs_wr23", wr_t[23], 1);
        check("rs_addr", addr_t[23], 12'h123);
        check("rs_data", wdata_t[23], 8'h5E);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
